if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 8-bit pipelined RISC core.
- Holds the PC and reads the instruction memory combinationally. Registers the fetched instruction and its PC into IF/ID for the decode/control stage, which sees opcode in bits [7:5].
- Handles stall, flush, branch/jump redirect and a HALT instruction.
- Injects a NOP bubble encoding, 8'hE0 (opcode 3'b111), which decode treats as all-control-signals-zero.

Parameters:
- PC_WIDTH, 8, width of PC and instruction-memory address.
- RESET_PC, 8'h00, PC value loaded on reset.
- CNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  PC_WIDTH  instruction-memory address; equals current PC, combinational.
- imem_rdata  in  8  instruction at imem_addr, valid same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  squash IF/ID to a bubble at next edge.
- redirect_valid  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  PC_WIDTH  target PC for the redirect.
- if_id_instr  out  8  registered instruction to decode.
- if_id_pc  out  PC_WIDTH  PC of if_id_instr.
- if_id_pc_plus1  out  PC_WIDTH  if_id_pc+1, mod 2^PC_WIDTH; for branch-target arithmetic.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  1 while the FSM is in HALTED.
- fetch_count  out  CNT_WIDTH  number of valid instructions delivered into IF/ID; saturating.

Behaviour:
- Reset (reset=1 at an edge), overriding everything:
  - pc=RESET_PC, if_id_instr=8'hE0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0.
  - State=RUN, halted=0, fetch_count=0.
  - A reset asserted mid-stall, mid-halt or mid-redirect behaves identically.
- FSM states are RUN and HALTED; halted = (state==HALTED).
- Per-edge priority when not in reset: redirect_valid > stall > normal fetch.
  - flush acts on IF/ID only; it does not alter the PC decision.
- Redirect (any state):
  - pc <= redirect_pc.
  - IF/ID <= bubble; redirect implies flush.
  - State <= RUN; a HALT fetched on the wrong path is cancelled.
  - Overrides a simultaneous stall.
- Stall (no redirect):
  - pc holds.
  - IF/ID holds, unless flush=1, in which case IF/ID <= bubble.
  - State holds; fetch_count holds.
- Normal fetch, RUN, no stall, no redirect:
  - If flush=0: if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_pc_plus1 <= pc+1, if_id_valid <= 1, fetch_count += 1.
  - If flush=1: IF/ID <= bubble, with no count.
  - pc <= pc+1 in both cases, wrapping FF->00 with no flag.
- HALT:
  - In RUN with no stall, no redirect and flush=0, a fetch of imem_rdata==8'hFF delivers 8'hFF into IF/ID as valid (counted), leaves pc unchanged and moves state to HALTED.
  - With flush=1 in the same cycle, the HALT is squashed and the FSM stays in RUN.
- HALTED, no redirect:
  - pc frozen; IF/ID <= bubble every cycle, including under stall or flush.
  - fetch_count frozen; only a redirect or reset leaves HALTED.
- fetch_count saturates at all-ones.
- Bubble encoding everywhere is instr=8'hE0, valid=0, pc fields=0.
- Latency: an instruction at address A appears on if_id_* one edge after imem_addr==A with no stall.

Test Plan:
- Reset then 4 free-running cycles, imem returns A0,A1,A2,A3 at pc 0..3 -> if_id_instr sequence E0(valid0),A0,A1,A2,A3; if_id_pc 0,1,2,3; fetch_count=4.
- Stall for 3 cycles with pc=5 and IF/ID holding instr 0x24 -> pc stays 5, if_id_instr stays 0x24, count unchanged; on release, pc=6 next edge.
- redirect_valid=1, redirect_pc=0x40 together with stall=1 at pc=7 -> next edge pc=0x40, if_id_valid=0, if_id_instr=E0; next edge fetches from 0x40.
- PC=0xFF normal fetch -> if_id_pc=FF, if_id_pc_plus1=00, pc wraps to 00.
- imem returns FF at pc=9 -> IF/ID=FF valid, halted=1, pc stays 9, bubbles follow. Then redirect to 0x10 -> halted=0, pc=0x10. Repeat with flush=1 on the HALT cycle -> halted stays 0, pc=0x0A.
- Reset asserted while HALTED and stalled -> next edge pc=RESET_PC, halted=0, fetch_count=0, if_id_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Handles stall, flush, redirect and HALT, and keeps a saturating count of fetched instructions.
module if_stage #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [7:0]           imem_rdata,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [7:0]           if_id_instr,
    output logic [PC_WIDTH-1:0]  if_id_pc,
    output logic [PC_WIDTH-1:0]  if_id_pc_plus1,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam logic [7:0] NOP_INSTR  = 8'hE0;
    localparam logic [7:0] HALT_INSTR = 8'hFF;

    // state   | meaning
    // S_RUN    | fetching normally
    // S_HALTED | HALT delivered; pc frozen, only bubbles until redirect/reset
    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic [PC_WIDTH-1:0]  w_pc_plus1;
    logic [7:0]           r_instr;
    logic [PC_WIDTH-1:0]  r_ifid_pc;
    logic [PC_WIDTH-1:0]  r_ifid_pc_plus1;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_load;
    logic                 w_bubble;

    assign w_pc_plus1 = r_pc + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: redirect > halted > stall > fetch; flush only affects IF/ID.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        if (redirect_valid) begin
            w_pc_next    = redirect_pc;
            w_bubble     = 1'b1;
            w_state_next = S_RUN;
        end else if (r_state == S_HALTED) begin
            w_bubble = 1'b1;
        end else if (stall) begin
            w_bubble = flush;
        end else if (flush) begin
            w_bubble  = 1'b1;
            w_pc_next = w_pc_plus1;
        end else begin
            w_load = 1'b1;
            if (imem_rdata == HALT_INSTR) begin
                w_state_next = S_HALTED;
            end else begin
                w_pc_next = w_pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_instr         <= NOP_INSTR;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus1 <= '0;
            r_valid         <= 1'b0;
            r_count         <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_load) begin
                r_instr         <= imem_rdata;
                r_ifid_pc       <= r_pc;
                r_ifid_pc_plus1 <= w_pc_plus1;
                r_valid         <= 1'b1;
                if (r_count != '1) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end
            end else if (w_bubble) begin
                r_instr         <= NOP_INSTR;
                r_ifid_pc       <= '0;
                r_ifid_pc_plus1 <= '0;
                r_valid         <= 1'b0;
            end
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_ifid_pc;
    assign if_id_pc_plus1 = r_ifid_pc_plus1;
    assign if_id_valid    = r_valid;
    assign halted         = (r_state == S_HALTED);
    assign fetch_count    = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural model pushes the expected post-edge state into a scoreboard,
// which is popped and compared after each edge, plus fixed-value checks for the key scenarios.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [7:0]  redirect_pc, imem_addr, imem_rdata;
    logic [7:0]  if_id_instr, if_id_pc, if_id_pc_plus1;
    logic        if_id_valid, halted;
    logic [15:0] fetch_count;
    logic [7:0]  mem [256];

    if_stage #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  instr;
        logic [7:0]  ipc;
        logic [7:0]  ipc1;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t bubble_of(exp_t s);
        exp_t n = s;
        n.instr = 8'hE0;
        n.valid = 1'b0;
        n.ipc   = 8'h00;
        n.ipc1  = 8'h00;
        return n;
    endfunction

    function automatic exp_t model(exp_t s, logic rst, logic st, logic fl, logic rv,
                                   logic [7:0] rpc, logic [7:0] rd);
        exp_t n = s;
        if (rst) begin
            n = bubble_of(s);
            n.pc = 8'h00; n.halted = 1'b0; n.cnt = 16'h0;
        end else if (rv) begin
            n = bubble_of(s);
            n.pc = rpc; n.halted = 1'b0;
        end else if (s.halted) begin
            n = bubble_of(s);
        end else if (st) begin
            if (fl) n = bubble_of(s);
        end else if (fl) begin
            n = bubble_of(s);
            n.pc = s.pc + 8'd1;
        end else begin
            n.instr = rd; n.valid = 1'b1; n.ipc = s.pc; n.ipc1 = s.pc + 8'd1;
            n.cnt = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 16'd1;
            if (rd == 8'hFF) n.halted = 1'b1;
            else             n.pc = s.pc + 8'd1;
        end
        return n;
    endfunction

    task automatic step(input logic rst, input logic st, input logic fl, input logic rv,
                        input logic [7:0] rpc);
        exp_t e;
        reset = rst; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        sb_q.push_back(model(m, rst, st, fl, rv, rpc, mem[m.pc]));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        m = e;
        check("pc",     imem_addr,      e.pc);
        check("instr",  if_id_instr,    e.instr);
        check("ifpc",   if_id_pc,       e.ipc);
        check("ifpc1",  if_id_pc_plus1, e.ipc1);
        check("valid",  if_id_valid,    e.valid);
        check("halted", halted,         e.halted);
        check("count",  fetch_count,    e.cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        m = '{pc: 8'h00, instr: 8'hE0, ipc: 8'h00, ipc1: 8'h00, valid: 1'b0, halted: 1'b0, cnt: 16'h0};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) & 8'h7F;
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3; mem[4] = 8'h24;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("tp_rst_instr", if_id_instr, 8'hE0);
        check("tp_rst_valid", if_id_valid, 1'b0);
        run(4);
        check("tp_seq_instr", if_id_instr, 8'hA3);
        check("tp_seq_pc",    if_id_pc,    8'h03);
        check("tp_seq_cnt",   fetch_count, 16'd4);

        run(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tp_stall_pc",    imem_addr,   8'h05);
        check("tp_stall_instr", if_id_instr, 8'h24);
        check("tp_stall_cnt",   fetch_count, 16'd5);
        run(1);
        check("tp_release_pc", imem_addr, 8'h06);

        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
        check("tp_redir_pc",    imem_addr,   8'h40);
        check("tp_redir_instr", if_id_instr, 8'hE0);
        run(1);
        check("tp_redir_fetch", if_id_pc, 8'h40);

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        run(1);
        check("tp_wrap_ifpc",  if_id_pc,       8'hFF);
        check("tp_wrap_plus1", if_id_pc_plus1, 8'h00);
        check("tp_wrap_pc",    imem_addr,      8'h00);

        mem[9] = 8'hFF;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        run(1);
        check("tp_halt_instr",  if_id_instr, 8'hFF);
        check("tp_halt_valid",  if_id_valid, 1'b1);
        check("tp_halt_flag",   halted,      1'b1);
        check("tp_halt_pc",     imem_addr,   8'h09);
        run(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("tp_halt_bubble", if_id_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        check("tp_unhalt_flag", halted,    1'b0);
        check("tp_unhalt_pc",   imem_addr, 8'h10);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("tp_flushhalt_flag", halted,    1'b0);
        check("tp_flushhalt_pc",   imem_addr, 8'h0A);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tp_rsthalt_pc",   imem_addr,   8'h00);
        check("tp_rsthalt_flag", halted,      1'b0);
        check("tp_rsthalt_cnt",  fetch_count, 16'd0);
        check("tp_rsthalt_vld",  if_id_valid, 1'b0);

        mem[9] = 8'h09;
        run(65540);
        check("tp_cnt_sat", fetch_count, 16'hFFFF);

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
